// File: rtl/gpio_handoff_ctrl.sv
// Break-before-make GPIO ownership handoff controller: tristates a pin, swaps its mux owner, then releases it.
// Optional feature macro: GPIO_HANDOFF_SKIP_SAME_EN (same-owner requests complete immediately).
module gpio_handoff_ctrl #(
    parameter int NUM_TEAMS  = 12,
    parameter int NUM_PINS   = 38,
    parameter int GAP_CYCLES = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  cfg_valid,
    input  logic [5:0]            cfg_pin,
    input  logic [3:0]            cfg_team,
    output logic                  cfg_ready,
    output logic [NUM_PINS*4-1:0] pin_sel,
    output logic [NUM_PINS-1:0]   force_oeb,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(GAP_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [5:0]              pin_q, pin_d;
    logic [3:0]              team_q, team_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [NUM_PINS*4-1:0]   pin_sel_q, pin_sel_d;
    logic [NUM_PINS-1:0]     force_oeb_q, force_oeb_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    req_bad;

    assign req_bad = (int'(cfg_pin) >= NUM_PINS) || (int'(cfg_team) > NUM_TEAMS);

`ifdef GPIO_HANDOFF_SKIP_SAME_EN
    logic [3:0] cur_team;

    always_comb begin
        cur_team = 4'd0;
        for (int p = 0; p < NUM_PINS; p++) begin
            if (p == int'(cfg_pin)) begin
                cur_team = pin_sel_q[p*4 +: 4];
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        pin_d       = pin_q;
        team_d      = team_q;
        cnt_d       = cnt_q;
        pin_sel_d   = pin_sel_q;
        force_oeb_d = force_oeb_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    pin_d  = cfg_pin;
                    team_d = cfg_team;
                    if (req_bad) begin
                        err_d = 1'b1;
`ifdef GPIO_HANDOFF_SKIP_SAME_EN
                    end else if (cfg_team == cur_team) begin
                        done_d = 1'b1;
`endif
                    end else begin
                        state_d = DRAIN;
                        cnt_d   = CNT_LOAD;
                        for (int p = 0; p < NUM_PINS; p++) begin
                            if (p == int'(cfg_pin)) begin
                                force_oeb_d[p] = 1'b1;
                            end
                        end
                    end
                end
            end

            DRAIN: begin
                // Old owner keeps the mux select until the pin has been tristated for the full gap.
                if (cnt_q == 4'd0) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_LOAD;
                    for (int p = 0; p < NUM_PINS; p++) begin
                        if (p == int'(pin_q)) begin
                            pin_sel_d[p*4 +: 4] = team_q;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    for (int p = 0; p < NUM_PINS; p++) begin
                        if (p == int'(pin_q)) begin
                            force_oeb_d[p] = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            pin_q       <= 6'd0;
            team_q      <= 4'd0;
            cnt_q       <= 4'd0;
            pin_sel_q   <= '0;
            force_oeb_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pin_q       <= pin_d;
            team_q      <= team_d;
            cnt_q       <= cnt_d;
            pin_sel_q   <= pin_sel_d;
            force_oeb_q <= force_oeb_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign pin_sel   = pin_sel_q;
    assign force_oeb = force_oeb_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_gpio_handoff_ctrl.sv
// Directed self-checking bench for gpio_handoff_ctrl with default parameters (38 pins, 12 teams, gap 4).
// Honours GPIO_HANDOFF_SKIP_SAME_EN so the same-owner case matches whichever build is under test.
module tb_gpio_handoff_ctrl;

    localparam int NUM_PINS  = 38;
    localparam int NUM_TEAMS = 12;
    localparam int GAP       = 4;

    logic                  clock;
    logic                  wbRstN;
    logic                  cfgValid;
    logic [5:0]            cfgPin;
    logic [3:0]            cfgTeam;
    logic                  cfgReady;
    logic [NUM_PINS*4-1:0] pinSel;
    logic [NUM_PINS-1:0]   forceOeb;
    logic                  busy;
    logic                  done;
    logic                  err;

    logic [NUM_PINS*4-1:0] expSel;
    logic [NUM_PINS-1:0]   expOeb;
    int                    checkCount;
    int                    errorCount;

    gpio_handoff_ctrl #(
        .NUM_TEAMS (NUM_TEAMS),
        .NUM_PINS  (NUM_PINS),
        .GAP_CYCLES(GAP)
    ) dut (
        .wb_clk_i (clock),
        .wb_rst_ni(wbRstN),
        .cfg_valid(cfgValid),
        .cfg_pin  (cfgPin),
        .cfg_team (cfgTeam),
        .cfg_ready(cfgReady),
        .pin_sel  (pinSel),
        .force_oeb(forceOeb),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge; outputs are then observed 1ns after the edge, i.e. in the new cycle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Present one request for exactly one edge; on return the bench sits in cycle 1.
    task automatic applyStimulus(input int pin, input int team);
        cfgValid = 1'b1;
        cfgPin   = 6'(pin);
        cfgTeam  = 4'(team);
        tick();
        cfgValid = 1'b0;
    endtask

    // Walk cycles 1..9 of a full handoff, updating the expected pin map as it goes; returns in the done cycle.
    task automatic watchHandoff(input string tag, input int pin, input int newTeam);
        for (int c = 1; c <= 2*GAP+1; c++) begin
            if (c == 1)       expOeb[pin] = 1'b1;
            if (c == GAP+1)   expSel[pin*4 +: 4] = 4'(newTeam);
            if (c == 2*GAP+1) expOeb[pin] = 1'b0;
            checkOutput({tag, "_sel"},   256'(pinSel),   256'(expSel));
            checkOutput({tag, "_oeb"},   256'(forceOeb), 256'(expOeb));
            checkOutput({tag, "_done"},  256'(done),     256'(c == 2*GAP+1));
            checkOutput({tag, "_busy"},  256'(busy),     256'(c != 2*GAP+1));
            checkOutput({tag, "_ready"}, 256'(cfgReady), 256'(c == 2*GAP+1));
            checkOutput({tag, "_err"},   256'(err),      256'(0));
            if (c < 2*GAP+1) tick();
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_sel"},   256'(pinSel),   256'(expSel));
        checkOutput({tag, "_oeb"},   256'(forceOeb), 256'(expOeb));
        checkOutput({tag, "_busy"},  256'(busy),     256'(0));
        checkOutput({tag, "_ready"}, 256'(cfgReady), 256'(1));
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        expSel     = '0;
        expOeb     = '0;
        wbRstN     = 1'b0;
        cfgValid   = 1'b0;
        cfgPin     = 6'd0;
        cfgTeam    = 4'd0;

        tick();
        tick();
        checkIdle("reset");
        checkOutput("reset_done", 256'(done), 256'(0));
        checkOutput("reset_err",  256'(err),  256'(0));
        wbRstN = 1'b1;
        tick();

        $display("[TB] basic handoff pin 5 -> team 3");
        applyStimulus(5, 3);
        watchHandoff("h5", 5, 3);
        tick();
        checkOutput("h5_done_clear", 256'(done), 256'(0));
        checkIdle("h5_after");

        $display("[TB] rejected requests");
        applyStimulus(38, 1);
        checkOutput("bad_pin_err", 256'(err), 256'(1));
        checkOutput("bad_pin_done", 256'(done), 256'(0));
        checkIdle("bad_pin");
        tick();
        checkOutput("bad_pin_err_clear", 256'(err), 256'(0));
        applyStimulus(2, 13);
        checkOutput("bad_team_err", 256'(err), 256'(1));
        checkIdle("bad_team");
        tick();
        checkOutput("bad_team_err_clear", 256'(err), 256'(0));
        checkIdle("bad_team_after");

        $display("[TB] request held while busy");
        applyStimulus(5, 6);
        cfgValid = 1'b1;
        cfgPin   = 6'd7;
        cfgTeam  = 4'd2;
        watchHandoff("h5b", 5, 6);
        tick();
        cfgValid = 1'b0;
        watchHandoff("h7", 7, 2);
        checkOutput("h7_pin5_kept", 256'(pinSel[5*4 +: 4]), 256'(6));
        tick();

        $display("[TB] boundary pin 37 team 12");
        applyStimulus(NUM_PINS-1, NUM_TEAMS);
        watchHandoff("h37", NUM_PINS-1, NUM_TEAMS);
        tick();

        $display("[TB] reset mid-handoff");
        applyStimulus(10, 4);
        for (int c = 1; c < 6; c++) tick();
        checkOutput("rst_mid_oeb_before", 256'(forceOeb[10]), 256'(1));
        wbRstN = 1'b0;
        tick();
        wbRstN = 1'b1;
        expSel = '0;
        expOeb = '0;
        checkIdle("rst_mid");
        checkOutput("rst_mid_done", 256'(done), 256'(0));
        for (int c = 0; c < 2*GAP+2; c++) begin
            tick();
            checkOutput("rst_mid_no_done", 256'(done), 256'(0));
        end

        $display("[TB] same-owner request");
        applyStimulus(0, 2);
        watchHandoff("h0", 0, 2);
        tick();
        applyStimulus(0, 2);
`ifdef GPIO_HANDOFF_SKIP_SAME_EN
        checkOutput("same_done", 256'(done), 256'(1));
        checkOutput("same_err",  256'(err),  256'(0));
        checkIdle("same");
        tick();
        checkOutput("same_done_clear", 256'(done), 256'(0));
        checkOutput("same_oeb_after", 256'(forceOeb), 256'(expOeb));
`else
        watchHandoff("same", 0, 2);
        tick();
        checkOutput("same_done_clear", 256'(done), 256'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
